// File: rtl/xor_descr_pkg.sv
// Shared types, default LFSR constants and the single Galois step used by the
// xor_stream_descrambler keystream generator.
package xor_descr_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } xds_state_e;

  localparam logic [15:0] DEF_POLY = 16'hB400;  // x^16+x^14+x^13+x^11+1
  localparam logic [15:0] DEF_SEED = 16'hACE1;

  // Widest LFSR the step function handles; narrower states are zero-extended.
  localparam int GALOIS_MAX_W = 64;

  function automatic logic [GALOIS_MAX_W-1:0] galois_step(
    input logic [GALOIS_MAX_W-1:0] s,
    input logic [GALOIS_MAX_W-1:0] poly
  );
    return (s >> 1) ^ (s[0] ? poly : '0);
  endfunction

endpackage

// File: rtl/galois_lfsr_adv.sv
// Combinational look-ahead: advances a Galois LFSR state by NSTEPS steps
// in a single cycle.
module galois_lfsr_adv
  import xor_descr_pkg::*;
#(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] POLY   = DEF_POLY,
  parameter int                NSTEPS = 8
) (
  input  logic [LFSR_W-1:0] S_IN,
  output logic [LFSR_W-1:0] S_OUT
);

  logic [LFSR_W-1:0] stage [NSTEPS+1];

  assign stage[0] = S_IN;

  for (genvar gi = 0; gi < NSTEPS; gi++) begin : g_step
    assign stage[gi+1] = LFSR_W'(galois_step(GALOIS_MAX_W'(stage[gi]),
                                             GALOIS_MAX_W'(POLY)));
  end

  assign S_OUT = stage[NSTEPS];

endmodule

// File: rtl/xor_stream_descrambler.sv
// Recovers A from a stream of A ^ keystream words using a locally regenerated
// Galois LFSR keystream. Optional word counter enabled by XDS_WORD_CNT_EN.
module xor_stream_descrambler
  import xor_descr_pkg::*;
#(
  parameter int                NBITS  = 8,
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] POLY   = DEF_POLY,
  parameter logic [LFSR_W-1:0] SEED   = DEF_SEED
`ifdef XDS_WORD_CNT_EN
  ,
  parameter int                CNT_W  = 16
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SEED_LOAD,
  input  logic [LFSR_W-1:0] SEED_IN,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [NBITS-1:0]  IN_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [NBITS-1:0]  OUT_DATA,
  output logic              LOCKED
`ifdef XDS_WORD_CNT_EN
  ,
  output logic [CNT_W-1:0]  WORD_CNT
`endif
);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_RUN  = RUN;

  logic [0:0]        state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [LFSR_W-1:0] lfsr_adv;
  logic              out_valid_q, out_valid_d;
  logic [NBITS-1:0]  out_data_q, out_data_d;
  logic              xfer;

  galois_lfsr_adv #(
    .LFSR_W (LFSR_W),
    .POLY   (POLY),
    .NSTEPS (NBITS)
  ) u_adv (
    .S_IN  (lfsr_q),
    .S_OUT (lfsr_adv)
  );

  // Single output register: accept when it is empty or being drained this cycle.
  assign IN_READY  = (state_q == ST_RUN) && !SEED_LOAD && (!out_valid_q || OUT_READY);
  assign xfer      = IN_VALID && IN_READY;
  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;
  assign LOCKED    = (state_q == ST_RUN);

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (SEED_LOAD) begin
      // A zero seed would lock the LFSR at zero, so fall back to the default.
      state_d     = ST_RUN;
      lfsr_d      = (SEED_IN == '0) ? SEED : SEED_IN;
      out_valid_d = 1'b0;
    end else if (xfer) begin
      out_data_d  = IN_DATA ^ lfsr_q[NBITS-1:0];
      out_valid_d = 1'b1;
      lfsr_d      = lfsr_adv;
    end else if (OUT_READY) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      lfsr_q      <= SEED;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef XDS_WORD_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (SEED_LOAD) begin
      cnt_d = '0;
    end else if (xfer) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign WORD_CNT = cnt_q;
`endif

endmodule
